// File: rtl/fetch_pc_gen_pkg.sv
// Shared frontend definitions: fetch reset vector, epoch width, the fetch packet
// handed to the fetch queue, and a PC increment helper.
package fetch_pc_gen_pkg;

   localparam logic [31:0] FETCH_RESET_PC = 32'h6000_0000;
   localparam int          FETCH_EPOCH_W  = 2;

   typedef logic [FETCH_EPOCH_W-1:0] epoch_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred_taken;
      logic [31:0] pred_pc;
      epoch_t      epoch;
   } fetch_pkt_t;

   // Sequential fetch step; wraps at 2^32 with no carry indication.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_pc_gen_perf_ctr.sv
// 32-bit saturating event counter used by fetch_pc_gen.
// Only compiled when FETCH_PC_PERF_EN is defined.
`ifdef FETCH_PC_PERF_EN
module fetch_perf_ctr (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule
`endif

// File: rtl/fetch_pc_gen.sv
// Front-end next-PC generator: holds the F1 fetch PC and drives the next PC to btb/I-cache.
// Optional FETCH_PC_PERF_EN adds saturating hit/redirect/stall counters as outputs.
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter int          EPOCH_W  = FETCH_EPOCH_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   input  logic               imem_stall,
   input  logic               btb_hit,
   input  logic [31:0]        btb_pc,
   output logic [31:0]        btb_req_pc,
   output logic               fetch_valid,
   input  logic               fetch_ready,
   output logic [31:0]        fetch_pc,
   output logic               fetch_pred_taken,
   output logic [31:0]        fetch_pred_pc,
   output logic [EPOCH_W-1:0] fetch_epoch
`ifdef FETCH_PC_PERF_EN
   ,
   output logic [31:0]        perf_btb_hit,
   output logic [31:0]        perf_redirect,
   output logic [31:0]        perf_stall
`endif
);

   logic [31:0]        f1_pc;
   logic               f1_valid;
   logic [EPOCH_W-1:0] epoch;
   logic               advance;
   logic [31:0]        next_pc;

   assign advance = f1_valid & fetch_ready & ~imem_stall & ~redirect_valid;

   // Next PC is presented combinationally so the BTB lookup next cycle is for the new F1 PC.
   always_comb begin
      next_pc = pc_plus4(f1_pc);
      if (redirect_valid) begin
         next_pc = {redirect_pc[31:2], 2'b00};
      end else if (!f1_valid || !advance) begin
         next_pc = f1_pc;
      end else if (btb_hit) begin
         next_pc = btb_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f1_pc    <= RESET_PC;
         f1_valid <= 1'b0;
         epoch    <= '0;
      end else begin
         f1_pc    <= next_pc;
         f1_valid <= 1'b1;
         if (redirect_valid) begin
            epoch <= epoch + EPOCH_W'(1);
         end
      end
   end

   assign btb_req_pc       = next_pc;
   assign fetch_valid      = f1_valid & ~redirect_valid & ~imem_stall;
   assign fetch_pc         = f1_pc;
   assign fetch_pred_taken = f1_valid & btb_hit;
   assign fetch_pred_pc    = fetch_pred_taken ? btb_pc : pc_plus4(f1_pc);
   assign fetch_epoch      = epoch;

`ifdef FETCH_PC_PERF_EN
   logic stall_cycle;

   // A stall cycle is a valid F1 entry that neither advances nor is being flushed.
   assign stall_cycle = f1_valid & ~advance & ~redirect_valid;

   fetch_perf_ctr u_perf_btb_hit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (fetch_pred_taken),
      .count (perf_btb_hit)
   );

   fetch_perf_ctr u_perf_redirect (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (redirect_valid),
      .count (perf_redirect)
   );

   fetch_perf_ctr u_perf_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_cycle),
      .count (perf_stall)
   );
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: directed cycles push expected fetch packets,
// a negedge monitor pops and compares every transfer to the fetch queue.
module tb_fetch_pc_gen;
   import fetch_pc_gen_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_stall;
   logic        btb_hit;
   logic [31:0] btb_pc;
   logic [31:0] btb_req_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic        fetch_pred_taken;
   logic [31:0] fetch_pred_pc;
   logic [1:0]  fetch_epoch;
`ifdef FETCH_PC_PERF_EN
   logic [31:0] perf_btb_hit;
   logic [31:0] perf_redirect;
   logic [31:0] perf_stall;
`endif

   int n_total = 0;
   int n_pass  = 0;
   fetch_pkt_t exp_q[$];

   fetch_pc_gen dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem_stall       (imem_stall),
      .btb_hit          (btb_hit),
      .btb_pc           (btb_pc),
      .btb_req_pc       (btb_req_pc),
      .fetch_valid      (fetch_valid),
      .fetch_ready      (fetch_ready),
      .fetch_pc         (fetch_pc),
      .fetch_pred_taken (fetch_pred_taken),
      .fetch_pred_pc    (fetch_pred_pc),
      .fetch_epoch      (fetch_epoch)
`ifdef FETCH_PC_PERF_EN
      ,
      .perf_btb_hit     (perf_btb_hit),
      .perf_redirect    (perf_redirect),
      .perf_stall       (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One cycle: drive inputs after the edge, optionally queue the expected transfer,
   // check the combinational request PC and fetch_valid mid-cycle, then step the clock.
   task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic stall,
                                input logic hit, input logic [31:0] bpc, input logic rdy,
                                input logic exp_fv, input logic [31:0] exp_req,
                                input logic push, input fetch_pkt_t pkt);
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_stall     = stall;
      btb_hit        = hit;
      btb_pc         = bpc;
      fetch_ready    = rdy;
      if (push) exp_q.push_back(pkt);
      #2;
      checkOutput("btb_req_pc", btb_req_pc, exp_req);
      checkOutput("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_fv});
      @(posedge clk);
      #1;
   endtask

   function automatic fetch_pkt_t mk(input logic [31:0] pc, input logic tk,
                                     input logic [31:0] ppc, input logic [1:0] ep);
      fetch_pkt_t p;
      p.pc = pc; p.pred_taken = tk; p.pred_pc = ppc; p.epoch = ep;
      return p;
   endfunction

   // Monitor: every accepted fetch must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && fetch_valid && fetch_ready) begin
         fetch_pkt_t got;
         fetch_pkt_t want;
         got = mk(fetch_pc, fetch_pred_taken, fetch_pred_pc, fetch_epoch);
         n_total++;
         if (exp_q.size() == 0) begin
            $display("[TB] FAIL xfer_unexpected: got pc=%h tk=%b ppc=%h ep=%0d, required none",
                     got.pc, got.pred_taken, got.pred_pc, got.epoch);
         end else begin
            want = exp_q.pop_front();
            if (got === want) n_pass++;
            else $display("[TB] FAIL xfer: got pc=%h tk=%b ppc=%h ep=%0d required pc=%h tk=%b ppc=%h ep=%0d",
                          got.pc, got.pred_taken, got.pred_pc, got.epoch,
                          want.pc, want.pred_taken, want.pred_pc, want.epoch);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   localparam fetch_pkt_t NONE = '0;

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_stall     = 1'b0;
      btb_hit        = 1'b1;
      btb_pc         = 32'h1234_5678;
      fetch_ready    = 1'b1;
      #12;
      checkOutput("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      checkOutput("rst_pred_taken", {31'd0, fetch_pred_taken}, 32'd0);
      checkOutput("rst_pred_pc", fetch_pred_pc, 32'h6000_0004);
      checkOutput("rst_btb_req_pc", btb_req_pc, 32'h6000_0000);
      checkOutput("rst_epoch", {30'd0, fetch_epoch}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset release and sequential fetch
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h6000_0000, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h6000_0004, 1, mk(32'h6000_0000, 0, 32'h6000_0004, 0));
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h6000_0008, 1, mk(32'h6000_0004, 0, 32'h6000_0008, 0));
      // Taken hits chaining without bubbles
      applyStimulus(0, 0, 0, 1, 32'h6000_0100, 1, 1, 32'h6000_0100, 1, mk(32'h6000_0008, 1, 32'h6000_0100, 0));
      applyStimulus(0, 0, 0, 1, 32'h6000_0010, 1, 1, 32'h6000_0010, 1, mk(32'h6000_0100, 1, 32'h6000_0010, 0));
      // Fetch queue backpressure: hold 6000_0010 for three cycles
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h6000_0010, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h6000_0010, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h6000_0010, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h6000_0014, 1, mk(32'h6000_0010, 0, 32'h6000_0014, 0));
      // I-cache stall, then redirect during stall with a competing BTB hit
      applyStimulus(0, 0, 1, 0, 0, 1, 0, 32'h6000_0014, 0, NONE);
      applyStimulus(1, 32'h6000_0203, 1, 1, 32'h6000_0900, 1, 0, 32'h6000_0200, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h6000_0204, 1, mk(32'h6000_0200, 0, 32'h6000_0204, 1));
      // Three more redirects: epoch 1 -> 2 -> 3 -> 0
      applyStimulus(1, 32'h6000_1001, 0, 0, 0, 1, 0, 32'h6000_1000, 0, NONE);
      applyStimulus(1, 32'h6000_2002, 0, 1, 32'h6000_0800, 1, 0, 32'h6000_2000, 0, NONE);
      applyStimulus(1, 32'h6000_3000, 0, 0, 0, 1, 0, 32'h6000_3000, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h6000_3004, 1, mk(32'h6000_3000, 0, 32'h6000_3004, 0));
      // 32-bit wrap of PC+4 and a self-looping hit
      applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 1, mk(32'h6000_3004, 1, 32'hFFFF_FFFC, 0));
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h0000_0000, 1, mk(32'hFFFF_FFFC, 0, 32'h0000_0000, 0));
      applyStimulus(0, 0, 0, 1, 32'h0000_0000, 1, 1, 32'h0000_0000, 1, mk(32'h0000_0000, 1, 32'h0000_0000, 0));
      applyStimulus(0, 0, 0, 1, 32'h0000_0000, 1, 1, 32'h0000_0000, 1, mk(32'h0000_0000, 1, 32'h0000_0000, 0));
      applyStimulus(1, 32'h6000_0500, 0, 0, 0, 1, 0, 32'h6000_0500, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h6000_0504, 1, mk(32'h6000_0500, 0, 32'h6000_0504, 1));

      // Asynchronous reset mid-stream, away from the clock edge
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      checkOutput("async_fetch_pc", fetch_pc, 32'h6000_0000);
      checkOutput("async_pred_pc", fetch_pred_pc, 32'h6000_0004);
      checkOutput("async_btb_req_pc", btb_req_pc, 32'h6000_0000);
      checkOutput("async_epoch", {30'd0, fetch_epoch}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h6000_0000, 0, NONE);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h6000_0004, 1, mk(32'h6000_0000, 0, 32'h6000_0004, 0));
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h6000_0004, 0, NONE);

      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
